// File: rtl/decode_stage_hz.sv
// Decode stage for the 5-stage RV32 core: register file with write-to-read bypass,
// load-use hazard detection, and an ID/EX pipeline register with hold, flush and valid.
module decode_stage_hz #(
  parameter int XLEN     = 32,
  parameter int NREGS    = 32,
  parameter int CTRL_W   = 11,
  parameter int LOAD_BIT = 9
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic [31:0]       InstrD,
  input  logic [XLEN-1:0]   PCD,
  input  logic [XLEN-1:0]   PCPlus4D,
  input  logic [XLEN-1:0]   ImmExtD,
  input  logic [CTRL_W-1:0] CtrlD,
  input  logic [XLEN-1:0]   ResultW,
  input  logic [4:0]        RdW,
  input  logic              RegWriteW,
  input  logic              FlushE,
  input  logic              StallE,
  output logic [4:0]        Rs1D,
  output logic [4:0]        Rs2D,
  output logic              StallF,
  output logic              StallD,
  output logic [XLEN-1:0]   RD1E,
  output logic [XLEN-1:0]   RD2E,
  output logic [XLEN-1:0]   PCE,
  output logic [XLEN-1:0]   ImmExtE,
  output logic [XLEN-1:0]   PCPlus4E,
  output logic [4:0]        Rs1E,
  output logic [4:0]        Rs2E,
  output logic [4:0]        RdE,
  output logic [CTRL_W-1:0] CtrlE,
  output logic [2:0]        funct3E,
  output logic              ValidE
);

  localparam int IDXW = $clog2(NREGS);

  logic [NREGS-1:0][XLEN-1:0] rf;
  logic [IDXW-1:0]            wr_idx;
  logic [IDXW-1:0]            rs1_idx;
  logic [IDXW-1:0]            rs2_idx;
  logic                       wr_en;
  logic [XLEN-1:0]            rd1;
  logic [XLEN-1:0]            rd2;
  logic                       lu;
  logic                       unused_bits;

  assign Rs1D    = InstrD[19:15];
  assign Rs2D    = InstrD[24:20];
  assign rs1_idx = Rs1D[IDXW-1:0];
  assign rs2_idx = Rs2D[IDXW-1:0];
  assign wr_idx  = RdW[IDXW-1:0];
  assign wr_en   = RegWriteW && (wr_idx != '0);

  // Opcode/funct7 are decoded by the external controller; RdW[4] is dropped for RV32E storage.
  assign unused_bits = ^{InstrD[31:25], InstrD[6:0], RdW};

  generate
    for (genvar gi = 0; gi < NREGS; gi++) begin : g_reg
      if (gi == 0) begin : g_zero
        assign rf[gi] = '0;
      end else begin : g_store
        logic [XLEN-1:0] q;
        always_ff @(posedge CLK or posedge RST) begin
          if (RST)
            q <= '0;
          else if (wr_en && (wr_idx == IDXW'(gi)))
            q <= ResultW;
        end
        assign rf[gi] = q;
      end
    end
  endgenerate

  // A same-cycle writeback is forwarded so decode never sees a stale value.
  assign rd1 = (wr_en && (wr_idx == rs1_idx)) ? ResultW : rf[rs1_idx];
  assign rd2 = (wr_en && (wr_idx == rs2_idx)) ? ResultW : rf[rs2_idx];

  assign lu = ValidE && CtrlE[LOAD_BIT] && (RdE != 5'd0) &&
              ((RdE == Rs1D) || (RdE == Rs2D));

  assign StallD = lu || StallE;
  assign StallF = lu || StallE;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      RD1E     <= '0;
      RD2E     <= '0;
      PCE      <= '0;
      ImmExtE  <= '0;
      PCPlus4E <= '0;
      Rs1E     <= '0;
      Rs2E     <= '0;
      RdE      <= '0;
      CtrlE    <= '0;
      funct3E  <= '0;
      ValidE   <= 1'b0;
    end else if (StallE) begin
      // Hold everything; a pending flush is re-presented once the hold drops.
    end else if (FlushE || lu) begin
      RD1E     <= '0;
      RD2E     <= '0;
      PCE      <= '0;
      ImmExtE  <= '0;
      PCPlus4E <= '0;
      Rs1E     <= '0;
      Rs2E     <= '0;
      RdE      <= '0;
      CtrlE    <= '0;
      funct3E  <= '0;
      ValidE   <= 1'b0;
    end else begin
      RD1E     <= rd1;
      RD2E     <= rd2;
      PCE      <= PCD;
      ImmExtE  <= ImmExtD;
      PCPlus4E <= PCPlus4D;
      Rs1E     <= InstrD[19:15];
      Rs2E     <= InstrD[24:20];
      RdE      <= InstrD[11:7];
      CtrlE    <= CtrlD;
      funct3E  <= InstrD[14:12];
      ValidE   <= 1'b1;
    end
  end

endmodule

// File: tb/tb_decode_stage_hz.sv
// Directed bench for decode_stage_hz: a behavioural model pushes the expected E-stage
// contents per step into a queue, which is popped and compared one clock later.
module tb_decode_stage_hz;

  logic        CLK, RST;
  logic [31:0] InstrD, PCD, PCPlus4D, ImmExtD, ResultW;
  logic [10:0] CtrlD;
  logic [4:0]  RdW;
  logic        RegWriteW, FlushE, StallE;

  logic [4:0]  Rs1D, Rs2D, Rs1E, Rs2E, RdE;
  logic        StallF, StallD, ValidE;
  logic [31:0] RD1E, RD2E, PCE, ImmExtE, PCPlus4E;
  logic [10:0] CtrlE;
  logic [2:0]  funct3E;

  logic [4:0]  e16_Rs1D, e16_Rs2D, e16_Rs1E, e16_Rs2E, e16_RdE;
  logic        e16_StallF, e16_StallD, e16_ValidE;
  logic [31:0] e16_RD1E, e16_RD2E, e16_PCE, e16_ImmExtE, e16_PCPlus4E;
  logic [10:0] e16_CtrlE;
  logic [2:0]  e16_funct3E;

  decode_stage_hz #(.XLEN(32), .NREGS(32), .CTRL_W(11), .LOAD_BIT(9)) dut (
    .CLK(CLK), .RST(RST), .InstrD(InstrD), .PCD(PCD), .PCPlus4D(PCPlus4D),
    .ImmExtD(ImmExtD), .CtrlD(CtrlD), .ResultW(ResultW), .RdW(RdW),
    .RegWriteW(RegWriteW), .FlushE(FlushE), .StallE(StallE),
    .Rs1D(Rs1D), .Rs2D(Rs2D), .StallF(StallF), .StallD(StallD),
    .RD1E(RD1E), .RD2E(RD2E), .PCE(PCE), .ImmExtE(ImmExtE), .PCPlus4E(PCPlus4E),
    .Rs1E(Rs1E), .Rs2E(Rs2E), .RdE(RdE), .CtrlE(CtrlE), .funct3E(funct3E),
    .ValidE(ValidE)
  );

  decode_stage_hz #(.XLEN(32), .NREGS(16), .CTRL_W(11), .LOAD_BIT(9)) dut16 (
    .CLK(CLK), .RST(RST), .InstrD(InstrD), .PCD(PCD), .PCPlus4D(PCPlus4D),
    .ImmExtD(ImmExtD), .CtrlD(CtrlD), .ResultW(ResultW), .RdW(RdW),
    .RegWriteW(RegWriteW), .FlushE(FlushE), .StallE(StallE),
    .Rs1D(e16_Rs1D), .Rs2D(e16_Rs2D), .StallF(e16_StallF), .StallD(e16_StallD),
    .RD1E(e16_RD1E), .RD2E(e16_RD2E), .PCE(e16_PCE), .ImmExtE(e16_ImmExtE),
    .PCPlus4E(e16_PCPlus4E), .Rs1E(e16_Rs1E), .Rs2E(e16_Rs2E), .RdE(e16_RdE),
    .CtrlE(e16_CtrlE), .funct3E(e16_funct3E), .ValidE(e16_ValidE)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  typedef struct {
    string       tag;
    logic [31:0] rd1, rd2, pc, imm, pc4;
    logic [4:0]  rs1, rs2, rd;
    logic [10:0] ctrl;
    logic [2:0]  f3;
    logic        valid;
  } exp_t;

  exp_t        sbq[$];
  exp_t        e_cur;
  logic [31:0] ref_rf [32];
  logic [31:0] pc_cnt;
  int          n_cmp = 0;
  int          n_bad = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic exp_t zero_exp(input string tag);
    exp_t z;
    z.tag = tag; z.rd1 = '0; z.rd2 = '0; z.pc = '0; z.imm = '0; z.pc4 = '0;
    z.rs1 = '0; z.rs2 = '0; z.rd = '0; z.ctrl = '0; z.f3 = '0; z.valid = 1'b0;
    return z;
  endfunction

  function automatic logic [31:0] rd_model(input logic [4:0] idx);
    if (RegWriteW && RdW != 5'd0 && RdW == idx) return ResultW;
    return ref_rf[idx];
  endfunction

  task automatic clear_model();
    for (int i = 0; i < 32; i++) ref_rf[i] = '0;
    e_cur = zero_exp("reset");
  endtask

  task automatic pop_check();
    exp_t e;
    if (sbq.size() == 0) begin
      check("sb_empty", 64'd1, 64'd0);
      return;
    end
    e = sbq.pop_front();
    check({e.tag, ".RD1E"}, RD1E, e.rd1);
    check({e.tag, ".RD2E"}, RD2E, e.rd2);
    check({e.tag, ".PCE"}, PCE, e.pc);
    check({e.tag, ".ImmExtE"}, ImmExtE, e.imm);
    check({e.tag, ".PCPlus4E"}, PCPlus4E, e.pc4);
    check({e.tag, ".Rs1E"}, Rs1E, e.rs1);
    check({e.tag, ".Rs2E"}, Rs2E, e.rs2);
    check({e.tag, ".RdE"}, RdE, e.rd);
    check({e.tag, ".CtrlE"}, CtrlE, e.ctrl);
    check({e.tag, ".funct3E"}, funct3E, e.f3);
    check({e.tag, ".ValidE"}, ValidE, e.valid);
  endtask

  // Drive one decode cycle, predict the E register, clock it, and compare.
  task automatic step(input string tag, input logic [31:0] instr, input logic [10:0] ctrl,
                      input logic we, input logic [4:0] wd, input logic [31:0] wdata,
                      input logic stall, input logic flush);
    exp_t nxt;
    logic lu_m;
    InstrD = instr; CtrlD = ctrl; RegWriteW = we; RdW = wd; ResultW = wdata;
    StallE = stall; FlushE = flush;
    PCD = pc_cnt; PCPlus4D = pc_cnt + 32'd4; ImmExtD = instr ^ 32'hA5A5_0000;
    pc_cnt = pc_cnt + 32'd4;
    #1;
    lu_m = e_cur.valid && e_cur.ctrl[9] && (e_cur.rd != 5'd0) &&
           ((e_cur.rd == instr[19:15]) || (e_cur.rd == instr[24:20]));
    check({tag, ".Rs1D"}, Rs1D, instr[19:15]);
    check({tag, ".StallD"}, StallD, lu_m || stall);
    check({tag, ".StallF"}, StallF, lu_m || stall);
    if (stall) begin
      nxt = e_cur;
    end else if (flush || lu_m) begin
      nxt = zero_exp("");
    end else begin
      nxt.rd1 = rd_model(instr[19:15]); nxt.rd2 = rd_model(instr[24:20]);
      nxt.pc = PCD; nxt.imm = ImmExtD; nxt.pc4 = PCPlus4D;
      nxt.rs1 = instr[19:15]; nxt.rs2 = instr[24:20]; nxt.rd = instr[11:7];
      nxt.ctrl = ctrl; nxt.f3 = instr[14:12]; nxt.valid = 1'b1;
    end
    nxt.tag = tag;
    sbq.push_back(nxt);
    @(posedge CLK);
    #1;
    if (we && wd != 5'd0) ref_rf[wd] = wdata;
    pop_check();
    e_cur = nxt;
    $display("step %-10s instr=%08h stallD=%0b validE=%0b RD1E=%08h RD2E=%08h RdE=%0d CtrlE=%03h",
             tag, instr, lu_m || stall, ValidE, RD1E, RD2E, RdE, CtrlE);
  endtask

  localparam logic [31:0] NOP      = 32'h0000_0013;
  localparam logic [31:0] ADD_4_33 = 32'h0031_8233;  // add x4,x3,x3
  localparam logic [31:0] ADD_8_7  = 32'h0003_8433;  // add x8,x7,x0
  localparam logic [31:0] ADD_8_0  = 32'h0000_0433;  // add x8,x0,x0
  localparam logic [31:0] LW_5     = 32'h0001_A283;  // lw x5,0(x3)
  localparam logic [31:0] ADD_6_5  = 32'h0002_8333;  // add x6,x5,x0
  localparam logic [31:0] ADD_2_1  = 32'h0100_8133;  // add x2,x1,x16

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    RST = 1'b1; InstrD = NOP; PCD = '0; PCPlus4D = '0; ImmExtD = '0; CtrlD = '0;
    ResultW = '0; RdW = '0; RegWriteW = 1'b0; FlushE = 1'b0; StallE = 1'b0;
    pc_cnt = 32'h0000_1000;
    clear_model();
    #2;
    check("rst.ValidE", ValidE, 1'b0);
    check("rst.RD1E", RD1E, 32'd0);
    check("rst.CtrlE", CtrlE, 11'd0);
    check("rst.e16_ValidE", e16_ValidE, 1'b0);
    @(posedge CLK);
    #1;
    RST = 1'b0;

    step("wr_x3", NOP, 11'h000, 1'b1, 5'd3, 32'h0000_1234, 1'b0, 1'b0);
    step("wr_x5", NOP, 11'h011, 1'b1, 5'd5, 32'h0000_0055, 1'b0, 1'b0);
    step("add", ADD_4_33, 11'h123, 1'b0, 5'd0, 32'h0, 1'b0, 1'b0);
    step("bypass", ADD_8_7, 11'h001, 1'b1, 5'd7, 32'hDEAD_BEEF, 1'b0, 1'b0);
    step("byp_x0", ADD_8_0, 11'h001, 1'b1, 5'd0, 32'h0000_FFFF, 1'b0, 1'b0);
    step("stored_x7", ADD_8_7, 11'h002, 1'b0, 5'd0, 32'h0, 1'b0, 1'b0);

    step("lw", LW_5, 11'h200, 1'b0, 5'd0, 32'h0, 1'b0, 1'b0);
    step("lu_bubble", ADD_6_5, 11'h001, 1'b0, 5'd0, 32'h0, 1'b0, 1'b0);
    step("lu_held", ADD_6_5, 11'h001, 1'b0, 5'd0, 32'h0, 1'b0, 1'b0);

    step("hold_fl", ADD_4_33, 11'h040, 1'b0, 5'd0, 32'h0, 1'b1, 1'b1);
    step("flush", ADD_4_33, 11'h040, 1'b0, 5'd0, 32'h0, 1'b0, 1'b1);
    step("after_fl", ADD_4_33, 11'h040, 1'b0, 5'd0, 32'h0, 1'b0, 1'b0);

    // Reset asserted while a load-use stall is pending.
    step("lw2", LW_5, 11'h200, 1'b0, 5'd0, 32'h0, 1'b0, 1'b0);
    InstrD = ADD_6_5;
    #1;
    check("midrst.StallD_pre", StallD, 1'b1);
    RST = 1'b1;
    #1;
    check("midrst.ValidE", ValidE, 1'b0);
    check("midrst.StallD", StallD, 1'b0);
    check("midrst.RD1E", RD1E, 32'd0);
    check("midrst.CtrlE", CtrlE, 11'd0);
    check("midrst.RdE", RdE, 5'd0);
    clear_model();
    RST = 1'b0;
    $display("midrst ValidE=%0b StallD=%0b", ValidE, StallD);
    step("x5_zero", ADD_6_5, 11'h001, 1'b0, 5'd0, 32'h0, 1'b0, 1'b0);

    // RV32E: x17 aliases x1, x16 aliases x0.
    step("wr_x17", NOP, 11'h000, 1'b1, 5'd17, 32'h0000_ABCD, 1'b0, 1'b0);
    step("rv32e", ADD_2_1, 11'h004, 1'b0, 5'd0, 32'h0, 1'b0, 1'b0);
    check("rv32e.RD1E", e16_RD1E, 32'h0000_ABCD);
    check("rv32e.RD2E", e16_RD2E, 32'd0);
    check("rv32e.Rs2E", e16_Rs2E, 5'd16);
    check("rv32e.ValidE", e16_ValidE, 1'b1);
    $display("rv32e RD1E=%08h RD2E=%08h", e16_RD1E, e16_RD2E);

    check("sb_drained", sbq.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/decode_stage_hz.md
Name: decode_stage_hz

Overview:
Parametrised next-generation decode stage and ID/EX pipeline register for the 5-stage RV32 core. It contains the register file with write-to-read bypass, the IF/ID stall path and load-use hazard detection. It also has an execute-side hold and a valid bit. The controller and immediate extender stay outside the block, so the control bundle width is generic.

Parameters:
XLEN, 32, datapath width of register data, PC and immediate
NREGS, 32, architectural register count (32 = RV32I, 16 = RV32E); index = low log2(NREGS) bits of the 5-bit field
CTRL_W, 11, width of the control bundle passed D->E
LOAD_BIT, 9, index in CtrlE that is 1 when the E-stage instruction is a load (ResultSrc LSB in the 11-bit bundle)

Ports:
CLK  in  1  clock, all state updates on posedge
RST  in  1  asynchronous active-high reset
InstrD  in  32  instruction in decode
PCD  in  XLEN  PC of decode instruction
PCPlus4D  in  XLEN  PC+4 of decode instruction
ImmExtD  in  XLEN  extended immediate from external extender
CtrlD  in  CTRL_W  control bundle from external controller
ResultW  in  XLEN  writeback data
RdW  in  5  writeback destination
RegWriteW  in  1  writeback enable
FlushE  in  1  branch/jump flush of E register
StallE  in  1  hold E register (multicycle execute)
Rs1D, Rs2D  out  5  InstrD[19:15], InstrD[24:20] (combinational)
StallF, StallD  out  1  hold PC / IF-ID register
RD1E, RD2E, PCE, ImmExtE, PCPlus4E  out  XLEN  E-stage operands
Rs1E, Rs2E, RdE  out  5  E-stage register indices
CtrlE  out  CTRL_W  E-stage control bundle
funct3E  out  3  E-stage funct3
ValidE  out  1  E register holds a real instruction

Behaviour:
- Reset (RST=1, async): every E output, including ValidE, goes to 0 immediately. All NREGS registers clear to 0.
- Register file write: on posedge, when RegWriteW=1 and the index is not 0. Register 0 always reads 0 and is never written.
- Read bypass: if RegWriteW=1, RdW equals the source index, and the index is not 0, the read value is ResultW (same-cycle write-then-read). Otherwise the read value is the stored value.
- Load-use hazard: LU = ValidE & CtrlE[LOAD_BIT] & (RdE != 0) & ((RdE == Rs1D) | (RdE == Rs2D)). Comparisons use all 5 bits.
- Stall outputs: StallD = StallF = LU | StallE. These are combinational.
- E register update priority per posedge, highest first:
  1. StallE=1: hold all E outputs unchanged, including ValidE. FlushE is ignored this cycle; the producer keeps FlushE asserted until StallE drops.
  2. FlushE=1 or LU=1: bubble. Every E output = 0, ValidE = 0.
  3. Otherwise load: RD1E/RD2E get the bypassed reads, PCE gets PCD, ImmExtE gets ImmExtD, PCPlus4E gets PCPlus4D, and Rs1E/Rs2E/RdE/funct3E get the InstrD fields. CtrlE gets CtrlD, ValidE gets 1.
- Latency: 1 cycle D->E. A load-use inserts exactly one bubble; on the next cycle LU deasserts because ValidE=0.
- When NREGS=16, index bit 4 is ignored for storage. Hazard compares still use all 5 bits.
- Reset asserted mid-stall clears ValidE, which releases StallD on the next evaluation.

Test Plan:
- Reset: RST=1 during activity -> all E outputs 0 and ValidE=0 without waiting for a clock; x5 reads 0 after release.
- Normal pass: write x3=0x1234 earlier; InstrD=0x00318233 (add x4,x3,x3) -> after 1 clock RD1E=RD2E=0x1234, RdE=4, Rs1E=Rs2E=3, ValidE=1, CtrlE=CtrlD.
- Bypass: RegWriteW=1, RdW=7, ResultW=0xDEADBEEF in the same cycle InstrD reads x7 -> RD1E=0xDEADBEEF after the edge; the same with RdW=0 -> RD1E=0.
- Load-use: E holds lw x5 (CtrlE[9]=1, ValidE=1, RdE=5), InstrD reads rs1=x5 -> StallD=StallF=1; next edge gives bubble (CtrlE=0, ValidE=0); the following edge loads the held instruction.
- Stall vs flush: StallE=1 and FlushE=1 together -> E unchanged; StallE drops with FlushE still 1 -> bubble.
- RV32E (NREGS=16): write x17 -> reads back via x1; x0 still reads 0.
